spm_prod_collect: RTL and testbench



---
 rtl/spm_pkg.sv | 12 +
 rtl/spm_bit_counter.sv | 40 ++++
 rtl/spm_prod_collect.sv | 116 +++++++++++
 tb/tb_spm_prod_collect.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared SPM datapath definitions: default operand width and the controller state encoding.
package spm_pkg;

  localparam int SPM_N = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } spm_state_e;

endpackage

// File: rtl/spm_bit_counter.sv
// Bit counter for the product collector; clear, enable and terminal count at 2N-1.
// Latency: one edge per count. Backpressure: none, the count follows the enable.
module spm_bit_counter
  import spm_pkg::*;
#(
  parameter int N = SPM_N
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] TC_VAL = CW'(2 * N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/spm_prod_collect.sv
// Deserialises the LSB-first 2N-bit SPM product stream and offers it with valid/ready.
// Latency: prod_valid rises 2N edges after the start edge. Backpressure: prod held until prod_ready.
// Optional: SPM_COLLECT_OVERRUN_EN adds a sticky 'overrun' flag for starts ignored while busy/holding.
module spm_prod_collect
  import spm_pkg::*;
#(
  parameter int N = SPM_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           bit_in,
  output logic [2*N-1:0] prod,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic           busy
`ifdef SPM_COLLECT_OVERRUN_EN
  ,
  output logic           overrun
`endif
);

  localparam int PW = 2 * N;

  spm_state_e    state_q, state_d;
  // Only 2N-1 bits are kept: the last bit is concatenated straight into prod.
  logic [PW-2:0] sr_q, sr_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;

  spm_bit_counter #(
    .N (N)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    prod_d  = prod_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          sr_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_COLLECT: begin
        sr_d   = {bit_in, sr_q[PW-2:1]};
        cnt_en = 1'b1;
        if (cnt_tc) begin
          prod_d  = {bit_in, sr_q};
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (prod_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      prod_q  <= prod_d;
    end
  end

  assign prod       = prod_q;
  assign prod_valid = (state_q == ST_HOLD);
  assign busy       = (state_q == ST_COLLECT);

`ifdef SPM_COLLECT_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A dropped start on the handshake edge still counts: set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (prod_valid && prod_ready) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spm_prod_collect.sv
// Directed self-checking bench for spm_prod_collect (N=64, 128-bit product).
module tb_spm_prod_collect;

  localparam int PW = 128;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          bit_in;
  logic [PW-1:0] prod;
  logic          prod_valid;
  logic          prod_ready;
  logic          busy;
`ifdef SPM_COLLECT_OVERRUN_EN
  logic          overrun;
`endif

  int total;
  int bad;

  spm_prod_collect #(.N(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .busy       (busy)
`ifdef SPM_COLLECT_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds 128 bits; counts cycles before the last bit where valid or busy is wrong.
  task automatic feed(input logic [PW-1:0] pat, input int start_at, output int bad_cyc);
    bad_cyc = 0;
    for (int i = 0; i < PW; i++) begin
      bit_in = pat[i];
      start  = (i == start_at);
      @(negedge clk);
      if (i < PW - 1 && (prod_valid !== 1'b0 || busy !== 1'b1)) bad_cyc++;
    end
    start  = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic test_reset_initial();
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; prod_ready = 1'b0;
    #1;
    total++; if (prod !== '0) begin bad++; $display("FAIL rst_prod: got %h want 0", prod); end
    total++; if (prod_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", prod_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
`ifdef SPM_COLLECT_OVERRUN_EN
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bc;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b want 1", busy); end
    feed(128'h0F, -1, bc);
    total++; if (bc !== 0) begin bad++; $display("FAIL basic_early: got %0d bad cycles want 0", bc); end
    total++; if (prod_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", prod_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    total++; if (prod !== 128'h0F) begin bad++; $display("FAIL basic_prod: got %h want %h", prod, 128'h0F); end
  endtask

  // Entered with the 3*5 product held; reset lands between edges.
  task automatic test_reset_hold();
    #2 rst_n = 1'b0;
    #1;
    total++; if (prod !== '0) begin bad++; $display("FAIL hold_rst_prod: got %h want 0", prod); end
    total++; if (prod_valid !== 1'b0) begin bad++; $display("FAIL hold_rst_valid: got %b want 0", prod_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bc;
    int held_bad;
    pulse_start();
    feed({PW{1'b1}}, -1, bc);
    total++; if (bc !== 0) begin bad++; $display("FAIL bp_early: got %0d bad cycles want 0", bc); end
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (prod !== {PW{1'b1}} || prod_valid !== 1'b1) held_bad++;
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", held_bad); end
    // Handshake with a simultaneous start: the start must be dropped.
    prod_ready = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    prod_ready = 1'b0;
    start      = 1'b0;
    total++; if (prod_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_clr: got %b want 0", prod_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_start_ignored: got busy %b want 0", busy); end
    total++; if (prod !== {PW{1'b1}}) begin bad++; $display("FAIL bp_prod_kept: got %h want all ones", prod); end
`ifdef SPM_COLLECT_OVERRUN_EN
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_setwins: got %b want 1", overrun); end
`endif
    @(negedge clk);
    total++; if (busy !== 1'b0 || prod_valid !== 1'b0) begin bad++; $display("FAIL bp_idle: got busy %b valid %b want 0 0", busy, prod_valid); end
  endtask

  task automatic test_start_in_collect();
    int bc;
    logic [PW-1:0] alt;
    alt = {64{2'b01}};
    pulse_start();
    feed(alt, 40, bc);
    total++; if (bc !== 0) begin bad++; $display("FAIL sic_early: got %0d bad cycles want 0", bc); end
    total++; if (prod !== 128'h5555_5555_5555_5555_5555_5555_5555_5555) begin bad++; $display("FAIL sic_prod: got %h want 5555...5555", prod); end
    total++; if (prod_valid !== 1'b1) begin bad++; $display("FAIL sic_valid: got %b want 1", prod_valid); end
`ifdef SPM_COLLECT_OVERRUN_EN
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL sic_overrun_set: got %b want 1", overrun); end
`endif
    prod_ready = 1'b1;
    @(negedge clk);
    prod_ready = 1'b0;
    total++; if (prod_valid !== 1'b0) begin bad++; $display("FAIL sic_valid_clr: got %b want 0", prod_valid); end
`ifdef SPM_COLLECT_OVERRUN_EN
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL sic_overrun_clr: got %b want 0", overrun); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_collect();
    int bc;
    pulse_start();
    for (int i = 0; i <= 70; i++) begin
      bit_in = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (prod !== '0) begin bad++; $display("FAIL mid_rst_prod: got %h want 0", prod); end
    @(negedge clk);
    bit_in = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    pulse_start();
    feed(128'h1, -1, bc);
    total++; if (bc !== 0) begin bad++; $display("FAIL mid_early: got %0d bad cycles want 0", bc); end
    total++; if (prod !== 128'h1 || prod_valid !== 1'b1) begin bad++; $display("FAIL mid_fresh: got %h valid %b want 1 valid 1", prod, prod_valid); end
    prod_ready = 1'b1;
    @(negedge clk);
    prod_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bc;
    prod_ready = 1'b1;
    pulse_start();
    feed(128'h2, -1, bc);
    total++; if (bc !== 0) begin bad++; $display("FAIL b2b_early0: got %0d bad cycles want 0", bc); end
    total++; if (prod_valid !== 1'b1 || prod !== 128'h2) begin bad++; $display("FAIL b2b_prod0: got %h valid %b want 2 valid 1", prod, prod_valid); end
    @(negedge clk);
    total++; if (prod_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse0: got %b want 0", prod_valid); end
    pulse_start();
    feed(128'h3, -1, bc);
    total++; if (bc !== 0) begin bad++; $display("FAIL b2b_early1: got %0d bad cycles want 0", bc); end
    total++; if (prod_valid !== 1'b1 || prod !== 128'h3) begin bad++; $display("FAIL b2b_prod1: got %h valid %b want 3 valid 1", prod, prod_valid); end
    @(negedge clk);
    total++; if (prod_valid !== 1'b0 || prod !== 128'h3) begin bad++; $display("FAIL b2b_pulse1: got %h valid %b want 3 valid 0", prod, prod_valid); end
    prod_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset_initial();
    test_basic();
    test_reset_hold();
    test_backpressure();
    test_start_in_collect();
    test_reset_mid_collect();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
